// File: rtl/recirc_shift_register_if.sv
// ----------------------------------------------------------------------------
// recirc_shift_register_if
//   Bundles the shift control, data and status signals of the recirculating
//   shift register. Clock and reset stay plain module ports.
//
//   shift_en  master->slave  request one stage shift on this edge
//   mode      master->slave  write source: 00 load, 01/11 recirculate, 10 zero
//   in        master->slave  data written by a load shift
//   out       slave->master  value that left on the most recent shift
//   index     slave->master  slot that leaves on the next shift
//   wrap      slave->master  one-cycle pulse after index wraps DEPTH-1 -> 0
//   busy      slave->master  high while the post-reset clear sweep runs
// ----------------------------------------------------------------------------
interface recirc_shift_register_if #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 40
) ();
    localparam int IDX_W = $clog2(DEPTH);

    logic             shift_en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [IDX_W-1:0] index;
    logic             wrap;
    logic             busy;

    modport master (
        output shift_en, mode, in,
        input  out, index, wrap, busy
    );

    modport slave (
        input  shift_en, mode, in,
        output out, index, wrap, busy
    );
endinterface

// File: rtl/recirc_shift_register.sv
// ----------------------------------------------------------------------------
// recirc_shift_register
//   WIDTH-bit x DEPTH-stage recirculating shift register built around a
//   read-first single-port RAM. After reset a hardware sweep zeroes every
//   slot (busy high for DEPTH clocks); afterwards each qualified shift reads
//   the slot at index onto out and rewrites that slot according to mode.
//
//   clock  in   rising-edge clock
//   reset  in   synchronous, active-high; restarts the clear sweep
//   bus    slave modport of recirc_shift_register_if
//                 shift_en/mode/in in, out/index/wrap/busy out
// ----------------------------------------------------------------------------
module recirc_shift_register #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 40
) (
    input  logic                    clock,
    input  logic                    reset,
    recirc_shift_register_if.slave  bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(DEPTH - 1);

    typedef enum logic {
        SWEEP,
        RUN
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] out_q;

    // NOTE: the storage array has no reset; the clear sweep defines its
    // contents, which keeps it mappable onto a plain synchronous RAM.
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             busy;
    logic             do_shift;
    logic             wr_en;
    logic [IDX_W-1:0] addr;
    logic [WIDTH-1:0] wr_data;

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state is assigned non-blocking so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= SWEEP;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every always_comb output gets a default first so no latch is
    // inferred on paths that do not assign it.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SWEEP:   if (sweep_q == LAST_SLOT) state_d = RUN;
            RUN:     state_d = RUN;
            default: state_d = SWEEP;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Recirculate (mode[0]=1) needs no write: leaving the slot untouched
    // keeps the value that was just placed on out, and it avoids a
    // read-modify-write path through the RAM.
    always_comb begin
        busy     = (state_q == SWEEP);
        do_shift = (state_q == RUN) && bus.shift_en;
        addr     = busy ? sweep_q : index_q;
        wr_en    = busy || (do_shift && !bus.mode[0]);
        wr_data  = (busy || bus.mode[1]) ? '0 : bus.in;
    end

    // ---------------- counters and strobe, next state ----------------
    always_comb begin
        sweep_d = sweep_q;
        if (busy) begin
            sweep_d = (sweep_q == LAST_SLOT) ? '0 : sweep_q + IDX_W'(1);
        end

        index_d = index_q;
        if (do_shift) begin
            index_d = (index_q == LAST_SLOT) ? '0 : index_q + IDX_W'(1);
        end

        wrap_d = do_shift && (index_q == LAST_SLOT);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sweep_q <= '0;
            index_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            sweep_q <= sweep_d;
            index_q <= index_d;
            wrap_q  <= wrap_d;
        end
    end

    // ---------------- storage ----------------
    // Read-first port: out takes the old slot contents on the same edge the
    // slot is rewritten, so a value re-emerges exactly DEPTH shifts later
    // with no bypass logic, even for DEPTH=2.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else if (do_shift) begin
            out_q <= mem_q[addr];
        end
    end

    assign bus.out   = out_q;
    assign bus.index = index_q;
    assign bus.wrap  = wrap_q;
    assign bus.busy  = busy;
endmodule

// File: tb/tb_recirc_shift_register.sv
module tb_recirc_shift_register;
    localparam logic [1:0] M_LOAD   = 2'b00;
    localparam logic [1:0] M_RECIRC = 2'b01;
    localparam logic [1:0] M_CLEAR  = 2'b10;
    localparam logic [1:0] M_ALT    = 2'b11;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    recirc_shift_register_if #(.WIDTH(6), .DEPTH(40)) ifa ();
    recirc_shift_register_if #(.WIDTH(1), .DEPTH(2))  ifb ();

    recirc_shift_register #(.WIDTH(6), .DEPTH(40)) dut_a (
        .clock (clk),
        .reset (rst_a),
        .bus   (ifa.slave)
    );

    recirc_shift_register #(.WIDTH(1), .DEPTH(2)) dut_b (
        .clock (clk),
        .reset (rst_b),
        .bus   (ifb.slave)
    );

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_a(input logic [1:0] m, input logic [5:0] d);
        ifa.shift_en = 1'b1;
        ifa.mode     = m;
        ifa.in       = d;
        step();
    endtask

    task automatic idle_a();
        ifa.shift_en = 1'b0;
        step();
    endtask

    task automatic load_lap_a();
        for (int s = 0; s < 40; s++) shift_a(M_LOAD, 6'(s));
    endtask

    // Reset with shift_en held high, then wait (bounded) for the sweep.
    task automatic reset_sweep_a();
        int n;
        rst_a        = 1'b1;
        ifa.shift_en = 1'b1;
        ifa.mode     = M_LOAD;
        ifa.in       = 6'h2A;
        step();
        rst_a = 1'b0;
        n = 0;
        while (ifa.busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        ifa.shift_en = 1'b0;
        total_cnt++;
        if (n !== 40) $display("FAIL sweep_len: busy cycles=%0d expected=40", n);
        else pass_cnt++;
        total_cnt++;
        if (ifa.out !== 6'd0 || ifa.index !== 6'd0 || ifa.wrap !== 1'b0)
            $display("FAIL post_sweep: out=%0d index=%0d wrap=%b expected 0/0/0",
                     ifa.out, ifa.index, ifa.wrap);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_a        = 1'b1;
        ifa.shift_en = 1'b1;
        ifa.mode     = M_LOAD;
        ifa.in       = 6'h3F;
        step();
        rst_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            total_cnt++;
            if (ifa.busy !== 1'b1 || ifa.index !== 6'd0 || ifa.out !== 6'd0 || ifa.wrap !== 1'b0)
                $display("FAIL reset_sweep clk %0d: busy=%b index=%0d out=%0d wrap=%b expected 1/0/0/0",
                         c, ifa.busy, ifa.index, ifa.out, ifa.wrap);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (ifa.busy !== 1'b0 || ifa.index !== 6'd0 || ifa.out !== 6'd0)
            $display("FAIL busy_release: busy=%b index=%0d out=%0d expected 0/0/0",
                     ifa.busy, ifa.index, ifa.out);
        else pass_cnt++;
        ifa.shift_en = 1'b0;
    endtask

    task automatic test_load_laps();
        logic [5:0] exp_out;
        logic       exp_wrap;
        reset_sweep_a();
        for (int s = 0; s < 80; s++) begin
            shift_a(M_LOAD, 6'(s));
            exp_out  = (s < 40) ? 6'd0 : 6'(s - 40);
            exp_wrap = (s == 39) || (s == 79);
            total_cnt++;
            if (ifa.out !== exp_out || ifa.index !== 6'((s + 1) % 40) || ifa.wrap !== exp_wrap)
                $display("FAIL load_laps shift %0d: out=%0d index=%0d wrap=%b expected %0d/%0d/%b",
                         s, ifa.out, ifa.index, ifa.wrap, exp_out, (s + 1) % 40, exp_wrap);
            else pass_cnt++;
        end
        idle_a();
        total_cnt++;
        if (ifa.wrap !== 1'b0 || ifa.out !== 6'd39 || ifa.index !== 6'd0)
            $display("FAIL load_laps idle: out=%0d index=%0d wrap=%b expected 39/0/0",
                     ifa.out, ifa.index, ifa.wrap);
        else pass_cnt++;
    endtask

    task automatic test_recirculate();
        reset_sweep_a();
        load_lap_a();
        for (int k = 0; k < 120; k++) begin
            shift_a((k % 2 == 1) ? M_ALT : M_RECIRC, 6'h3F);
            total_cnt++;
            if (ifa.out !== 6'(k % 40))
                $display("FAIL recirculate shift %0d: out=%0d expected %0d", k, ifa.out, k % 40);
            else pass_cnt++;
        end
        ifa.shift_en = 1'b0;
    endtask

    task automatic test_clear();
        reset_sweep_a();
        load_lap_a();
        for (int k = 0; k < 40; k++) begin
            shift_a(M_CLEAR, 6'h15);
            total_cnt++;
            if (ifa.out !== 6'(k))
                $display("FAIL clear_lap shift %0d: out=%0d expected %0d", k, ifa.out, k);
            else pass_cnt++;
        end
        for (int k = 0; k < 40; k++) begin
            shift_a(M_RECIRC, 6'h15);
            total_cnt++;
            if (ifa.out !== 6'd0)
                $display("FAIL after_clear shift %0d: out=%0d expected 0", k, ifa.out);
            else pass_cnt++;
        end
        ifa.shift_en = 1'b0;
    endtask

    // shift_en pattern 1,0,0 repeating over two load laps.
    task automatic test_gaps();
        logic [5:0] exp_out;
        logic       exp_wrap;
        reset_sweep_a();
        for (int s = 0; s < 80; s++) begin
            shift_a(M_LOAD, 6'(s));
            exp_out  = (s < 40) ? 6'd0 : 6'(s - 40);
            exp_wrap = (s == 39) || (s == 79);
            total_cnt++;
            if (ifa.out !== exp_out || ifa.index !== 6'((s + 1) % 40) || ifa.wrap !== exp_wrap)
                $display("FAIL gaps shift %0d: out=%0d index=%0d wrap=%b expected %0d/%0d/%b",
                         s, ifa.out, ifa.index, ifa.wrap, exp_out, (s + 1) % 40, exp_wrap);
            else pass_cnt++;
            for (int g = 0; g < 2; g++) begin
                idle_a();
                total_cnt++;
                if (ifa.out !== exp_out || ifa.index !== 6'((s + 1) % 40) || ifa.wrap !== 1'b0)
                    $display("FAIL gaps hold %0d.%0d: out=%0d index=%0d wrap=%b expected %0d/%0d/0",
                             s, g, ifa.out, ifa.index, ifa.wrap, exp_out, (s + 1) % 40);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_sweep_a();
        load_lap_a();
        for (int s = 0; s < 25; s++) shift_a(M_LOAD, 6'(40 + s));
        reset_sweep_a();
        for (int k = 0; k < 40; k++) begin
            shift_a(M_RECIRC, 6'h3F);
            total_cnt++;
            if (ifa.out !== 6'd0)
                $display("FAIL reset_mid shift %0d: out=%0d expected 0", k, ifa.out);
            else pass_cnt++;
        end
        ifa.shift_en = 1'b0;
    endtask

    // WIDTH=1, DEPTH=2: load 1,0,1,0,1,0 -> out 0,0,1,0,1,0.
    task automatic test_depth2();
        int   n;
        logic exp_out;
        rst_b        = 1'b1;
        ifb.shift_en = 1'b1;
        ifb.mode     = M_LOAD;
        ifb.in       = 1'b1;
        step();
        rst_b = 1'b0;
        n = 0;
        while (ifb.busy === 1'b1 && n < 20) begin
            n++;
            step();
        end
        total_cnt++;
        if (n !== 2) $display("FAIL depth2_sweep: busy cycles=%0d expected=2", n);
        else pass_cnt++;
        for (int k = 0; k < 6; k++) begin
            ifb.shift_en = 1'b1;
            ifb.mode     = M_LOAD;
            ifb.in       = (k % 2 == 0);
            step();
            exp_out = (k >= 2) && (k % 2 == 0);
            total_cnt++;
            if (ifb.out !== exp_out || ifb.index !== 1'((k + 1) % 2) || ifb.wrap !== 1'(k % 2))
                $display("FAIL depth2 shift %0d: out=%b index=%0d wrap=%b expected %b/%0d/%0d",
                         k, ifb.out, ifb.index, ifb.wrap, exp_out, (k + 1) % 2, k % 2);
            else pass_cnt++;
        end
        ifb.shift_en = 1'b0;
    endtask

    initial begin
        rst_a        = 1'b1;
        rst_b        = 1'b1;
        ifa.shift_en = 1'b0;
        ifa.mode     = M_LOAD;
        ifa.in       = '0;
        ifb.shift_en = 1'b0;
        ifb.mode     = M_LOAD;
        ifb.in       = '0;
        step();
        test_reset();
        test_load_laps();
        test_recirculate();
        test_clear();
        test_gaps();
        test_reset_mid();
        test_depth2();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/recirc_shift_register.md
Name: recirc_shift_register

Overview:
- Parametrised successor to the Signetics 2519 model: a WIDTH-bit by DEPTH-stage recirculating shift register with a shift-enable qualifier, per-shift write mode (load / recirculate / clear), a slot index output and a wrap strobe.
- Used as the display/line-buffer memory in the Apple-1 video path.
- Contents are defined after reset by a hardware clear sweep, and stepping can be gated by the character clock.

Parameters:
- WIDTH, 6, bits per stage (number of parallel channels); must be >= 1.
- DEPTH, 40, stages per channel; must be >= 2.
- IDX_W, $clog2(DEPTH) (local), width of the index output.

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- shift_en  in  1  one stage shift on this edge when high and busy is low.
- mode  in  2  per-shift write source:
  - 00: load `in`.
  - 01: recirculate the value leaving.
  - 10: write zero.
  - 11: treated as 01.
- in  in  WIDTH  data written on a load shift.
- out  out  WIDTH  registered output: the value leaving on the most recent shift.
- index  out  IDX_W  number of the slot that leaves on the next shift, 0..DEPTH-1.
- wrap  out  1  one-cycle pulse after the shift that moves index from DEPTH-1 to 0.
- busy  out  1  high during the clear sweep; shifts are ignored while high.

Behaviour:
- Reset (reset=1 at an edge) sets:
  - out=0, index=0, wrap=0, busy=1.
  - Sweep counter = 0.
  - Any shift_en on that edge is ignored.
- Reset has priority over everything. Asserting it mid-sweep or mid-operation restarts the sweep from slot 0.
- Clear sweep, states SWEEP and RUN:
  - SWEEP: write zero to one slot per clock, slots 0..DEPTH-1 in order, taking exactly DEPTH clocks after reset deasserts.
  - On the edge that writes slot DEPTH-1: busy goes 0 and the state becomes RUN.
  - During SWEEP: out holds 0, index holds 0, wrap stays 0, and shift_en is dropped (not queued).
- Shift (RUN and shift_en=1) on edge t:
  - out <= the value written by the shift DEPTH shifts earlier.
  - Slots never written since the sweep read 0.
  - The slot is rewritten according to mode sampled on edge t:
    - load: writes `in` sampled at t.
    - recirculate: writes the value now placed on out.
    - clear: writes 0.
  - index <= index+1, wrapping DEPTH-1 -> 0.
  - wrap <= 1 exactly when the old index was DEPTH-1, otherwise 0.
- No shift (shift_en=0, or busy=1):
  - out, index and contents hold.
  - wrap <= 0, so wrap is never high for two consecutive cycles.
- Latency:
  - The value written at shift n appears on out at shift n+DEPTH, counted in shifts, not clocks.
  - Gaps in shift_en do not change that ordering.
- A sustained recirculate is lossless: the output sequence repeats with period DEPTH shifts.
- Mixing modes shift by shift is legal. Each shift affects only its own slot.
- Back-to-back shifts every clock are supported with no bubbles. A synchronous single-port or simple dual-port RAM must be inferable. Any internal deferral of writes must remain invisible at the ports: a slot re-read DEPTH shifts later returns the written value, including when DEPTH=2.
- X-free: out is never X after reset, regardless of `in` before the first load.

Test Plan:
- WIDTH=6, DEPTH=40:
  - Reset for 1 clock -> busy=1 for exactly 40 clocks, then 0. During those clocks shift_en=1 leaves index=0 and out=0.
  - Then 40 load shifts of in=0..39 -> out=0 throughout. The next 40 load shifts of in=40..79 -> out=0..39 in order. wrap pulses after the 40th and 80th shifts only.
  - After loading 0..39 (one full lap), 120 recirculate shifts with in=6'h3F -> out repeats 0..39 three times and 6'h3F never appears.
  - Load 0..39, then one lap of clear, then one lap of recirculate -> out during the clear lap = 0..39. During the recirculate lap out = all 0.
  - Load 0..39 with shift_en toggling 1,0,0,1,... -> the out sequence equals the gapless case. out and index hold during the gaps, and wrap is one clock wide.
  - Assert reset at shift 25 of the second lap -> busy=1 for 40 clocks, then out=0 and index=0. The next lap of recirculate outputs all 0.
- WIDTH=1, DEPTH=2: alternate load 1,0,1,0 every clock -> out=0,0,1,0,1,0. index toggles 0/1 and wrap pulses every second shift.
